// File: rtl/tinyalu_pkg.sv
// Shared definitions for the TinyALU command driver: opcodes, FSM states
// and the idle-gap LFSR.
package tinyalu_pkg;

  localparam logic [2:0] NO_OP  = 3'b000;
  localparam logic [2:0] ADD_OP = 3'b001;
  localparam logic [2:0] AND_OP = 3'b010;
  localparam logic [2:0] XOR_OP = 3'b011;
  localparam logic [2:0] MUL_OP = 3'b100;
  localparam logic [2:0] RST_OP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_ALU_RST = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO, first-word-fall-through: rdata shows the head entry
// whenever empty is low, and pop simply advances to the next one.
module alu_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers flush it.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head word and occupancy flags.
  always_comb begin
    rdata = mem[rd_ptr[AW-1:0]];
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// TinyALU command driver: buffers commands, issues them to the ALU with the
// start/done handshake (or pulses the ALU reset for rst_op), copies each
// issued command to a predictor port and spaces operations with idle gaps.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is raised, the payload is held stable and valid stays
// high until that transfer; ready may change freely.
module alu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_W      = 2,
  parameter int TIMEOUT    = 255,
  parameter int RST_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_reset_n,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  output logic              pred_valid,
  input  logic              pred_ready,
  output logic [2:0]        pred_op,
  output logic [DATA_W-1:0] pred_a,
  output logic [DATA_W-1:0] pred_b,
  input  logic              gap_mode,
  input  logic [GAP_W-1:0]  gap_cfg,
  output logic              busy,
  output logic              timeout_err,
  output state_e            dbg_state
);

  localparam int FW = 3 + 2*DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYC + 1);

  state_e            state_q, state_d;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              head_seen_q;
  logic              pop_ok, enter_gap, set_tout;
  logic [2:0]        head_op;
  logic [DATA_W-1:0] head_a, head_b;
  logic [TW-1:0]     tcnt_q;
  logic [RW-1:0]     rcnt_q;
  logic [GAP_W-1:0]  gapcnt_q;
  logic [15:0]       lfsr_q;

  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {head_op, head_a, head_b} = fifo_rdata;
  assign dbg_state = state_q;

  // The head word must have been present for one full cycle before it is
  // taken, which fixes acceptance-to-start at two cycles without slowing
  // back-to-back issue from a non-empty FIFO.
  assign pop_ok = !fifo_empty && head_seen_q && (!pred_valid || pred_ready);

  alu_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the strobes that steer the datapath.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    set_tout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pop_ok) begin
          fifo_pop = 1'b1;
          state_d  = (head_op == RST_OP) ? ST_ALU_RST : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (alu_done || (alu_op == NO_OP)) begin
          state_d = ST_GAP;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = ST_GAP;
          set_tout = 1'b1;
        end
      end
      ST_ALU_RST: begin
        if (rcnt_q <= RW'(1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gapcnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    enter_gap = (state_d == ST_GAP) && (state_q != ST_GAP);
  end

  // Outputs decoded from the current state.
  always_comb begin
    alu_start   = (state_q == ST_ISSUE);
    alu_reset_n = !reset && (state_q != ST_ALU_RST);
    busy        = (state_q != ST_IDLE) || !fifo_empty;
  end

  // Datapath: ALU and predictor registers, counters, LFSR, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      pred_valid  <= 1'b0;
      pred_op     <= '0;
      pred_a      <= '0;
      pred_b      <= '0;
      tcnt_q      <= '0;
      rcnt_q      <= '0;
      gapcnt_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      timeout_err <= 1'b0;
      head_seen_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_next(lfsr_q);
      head_seen_q <= !fifo_empty;

      if (fifo_pop) begin
        pred_valid <= 1'b1;
        pred_op    <= head_op;
        pred_a     <= head_a;
        pred_b     <= head_b;
      end else if (pred_ready) begin
        pred_valid <= 1'b0;
      end

      if (fifo_pop && (head_op != RST_OP)) begin
        alu_op <= head_op;
        alu_a  <= head_a;
        alu_b  <= head_b;
      end

      if (fifo_pop)                 tcnt_q <= '0;
      else if (state_q == ST_ISSUE) tcnt_q <= tcnt_q + TW'(1);

      if (fifo_pop && (head_op == RST_OP)) rcnt_q <= RW'(RST_CYC);
      else if (state_q == ST_ALU_RST)      rcnt_q <= rcnt_q - RW'(1);

      if (enter_gap)
        gapcnt_q <= gap_mode ? lfsr_q[GAP_W-1:0] : gap_cfg;
      else if ((state_q == ST_GAP) && (gapcnt_q != '0))
        gapcnt_q <= gapcnt_q - GAP_W'(1);

      if (set_tout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a vector table for single commands plus
// hand-written sequences for no_op spacing, rst_op, back-pressure, timeout
// and reset in the middle of an operation.
module tb_alu_cmd_driver;
  import tinyalu_pkg::*;

  localparam int W = 19;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       alu_reset_n, alu_start, alu_done;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       pred_valid, pred_ready;
  logic [2:0] pred_op;
  logic [7:0] pred_a, pred_b;
  logic       gap_mode;
  logic [1:0] gap_cfg;
  logic       busy, timeout_err;
  state_e     dbg_state;

  alu_cmd_driver #(
    .DATA_W(8), .FIFO_DEPTH(4), .GAP_W(2), .TIMEOUT(8), .RST_CYC(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_reset_n(alu_reset_n), .alu_start(alu_start),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_op(pred_op), .pred_a(pred_a), .pred_b(pred_b),
    .gap_mode(gap_mode), .gap_cfg(gap_cfg),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock and a global guard against hangs.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pexp_q[$];
  logic [W-1:0] held_w;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;
  int st_cyc = 0;
  int done_delay = 3;
  logic start_prev = 1'b0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         dd;
    logic       gm;
    logic [1:0] gc;
    int         exp_len;
    int         exp_gap;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: handshake bookkeeping before the edge, output checks and the
  // ALU responder 1 time unit after it.
  task automatic tick();
    logic [W-1:0] w;
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        w = {cmd_op, cmd_a, cmd_b};
        if (cmd_op != RST_OP) exp_q.push_back(w);
        pexp_q.push_back(w);
      end
      if (pred_valid && pred_ready) begin
        check("pred_qlen", 32'(pexp_q.size() != 0), 32'd1);
        if (pexp_q.size() != 0)
          check("pred_word", 32'({pred_op, pred_a, pred_b}), 32'(pexp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (alu_start && !start_prev) begin
      n_start++;
      held_w = {alu_op, alu_a, alu_b};
      check("issue_qlen", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("issue_word", 32'(held_w), 32'(exp_q.pop_front()));
    end else if (alu_start && start_prev) begin
      check("issue_hold", 32'({alu_op, alu_a, alu_b}), 32'(held_w));
    end
    start_prev = alu_start;
    st_cyc = alu_start ? st_cyc + 1 : 0;
    alu_done = alu_start && (done_delay >= 0) && (st_cyc == done_delay + 1);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic acc = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_start(output int c);
    int t = 0;
    while (!alu_start && t < 40) begin tick(); t++; end
    check("start_seen", 32'(alu_start), 32'd1);
    c = cyc;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || pred_valid) && t < 300) begin tick(); t++; end
    check("idle_reached", 32'(busy || pred_valid), 32'd0);
  endtask

  int acc_c, s, s1, s2, len, g, n, base;

  initial begin
    vecs[0] = '{ADD_OP, 8'h12, 8'h34, 3, 1'b0, 2'd0, 4, 1};
    vecs[1] = '{AND_OP, 8'hFF, 8'h0F, 0, 1'b0, 2'd1, 1, 2};
    vecs[2] = '{XOR_OP, 8'hA5, 8'h5A, 1, 1'b0, 2'd2, 2, 3};
    vecs[3] = '{MUL_OP, 8'h0F, 8'h11, 5, 1'b0, 2'd3, 6, 4};
    vecs[4] = '{3'b101, 8'h01, 8'h02, 2, 1'b0, 2'd0, 3, 1};
    vecs[5] = '{NO_OP,  8'h77, 8'h88, 2, 1'b0, 2'd0, 1, 1};
    vecs[6] = '{ADD_OP, 8'h00, 8'h00, 0, 1'b1, 2'd0, 1, -1};
    vecs[7] = '{3'b110, 8'h80, 8'h7F, 1, 1'b0, 2'd1, 2, 2};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    pred_ready = 1'b1; gap_mode = 1'b0; gap_cfg = '0; alu_done = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_alu_reset_n", 32'(alu_reset_n), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_alu_regs", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_alu_reset_n", 32'(alu_reset_n), 32'd1);

    // Table of single commands: latency, operands, pred copy, start width, gap.
    for (int i = 0; i < 8; i++) begin
      gap_mode = vecs[i].gm; gap_cfg = vecs[i].gc; done_delay = vecs[i].dd;
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      acc_c = cyc;
      wait_start(s);
      check("latency", 32'(s - acc_c), 32'd2);
      check("alu_word", 32'({alu_op, alu_a, alu_b}), 32'({vecs[i].op, vecs[i].a, vecs[i].b}));
      check("pred_valid_on_issue", 32'(pred_valid), 32'd1);
      check("pred_copy", 32'({pred_op, pred_a, pred_b}), 32'({vecs[i].op, vecs[i].a, vecs[i].b}));
      len = 0;
      while (alu_start && len < 50) begin len++; tick(); end
      check("start_len", 32'(len), 32'(vecs[i].exp_len));
      g = 0;
      while (busy && g < 20) begin g++; tick(); end
      if (vecs[i].exp_gap < 0) check("gap_rand_range", 32'(g >= 1 && g <= 4), 32'd1);
      else                     check("gap_len", 32'(g), 32'(vecs[i].exp_gap));
      check("no_timeout", 32'(timeout_err), 32'd0);
    end
    wait_idle();

    // no_op: one-cycle start without done, next start three cycles later.
    gap_mode = 1'b0; gap_cfg = 2'd0; done_delay = -1;
    send_cmd(NO_OP, 8'h00, 8'h00);
    send_cmd(ADD_OP, 8'h21, 8'h43);
    wait_start(s1);
    done_delay = 0;
    tick();
    check("noop_start_1cyc", 32'(alu_start), 32'd0);
    wait_start(s2);
    check("noop_spacing", 32'(s2 - s1), 32'd3);
    wait_idle();

    // rst_op: ALU reset low for two cycles, no start, pred copy delivered.
    base = n_start;
    send_cmd(RST_OP, 8'h00, 8'h00);
    n = 0;
    while (alu_reset_n && n < 20) begin tick(); n++; end
    check("rstop_seen", 32'(alu_reset_n), 32'd0);
    check("rstop_pred", 32'({pred_valid, pred_op}), 32'({1'b1, RST_OP}));
    n = 0;
    while (!alu_reset_n && n < 20) begin
      check("rstop_no_start", 32'(alu_start), 32'd0);
      n++; tick();
    end
    check("rstop_len", 32'(n), 32'd2);
    wait_idle();
    check("rstop_no_issue", 32'(n_start - base), 32'd0);

    // Back-pressure: predictor stalled, five accepted, sixth refused.
    base = n_start; done_delay = 0; pred_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(3'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i));
    cmd_op = XOR_OP; cmd_a = 8'hC6; cmd_b = 8'h6C; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready_low", 32'(cmd_ready), 32'd0);
      tick();
    end
    check("bp_busy", 32'(busy), 32'd1);
    pred_ready = 1'b1;
    send_cmd(XOR_OP, 8'hC6, 8'h6C);
    wait_idle();
    check("bp_issue_count", 32'(n_start - base), 32'd6);
    check("bp_exp_empty", 32'(exp_q.size() + pexp_q.size()), 32'd0);

    // Timeout: done never comes, start drops after 8 cycles, error sticks.
    done_delay = -1;
    send_cmd(ADD_OP, 8'h01, 8'h01);
    wait_start(s);
    len = 0;
    while (alu_start && len < 50) begin len++; tick(); end
    check("tout_len", 32'(len), 32'd8);
    check("tout_err_set", 32'(timeout_err), 32'd1);
    done_delay = 0;
    send_cmd(XOR_OP, 8'h3C, 8'hC3);
    wait_start(s);
    check("tout_next_word", 32'({alu_op, alu_a, alu_b}), 32'({XOR_OP, 8'h3C, 8'hC3}));
    wait_idle();
    check("tout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-operation with two commands queued.
    done_delay = -1;
    send_cmd(MUL_OP, 8'h05, 8'h06);
    wait_start(s);
    send_cmd(ADD_OP, 8'h07, 8'h08);
    send_cmd(AND_OP, 8'h09, 8'h0A);
    check("midrst_start_high", 32'(alu_start), 32'd1);
    reset = 1'b1;
    exp_q.delete(); pexp_q.delete();
    tick();
    check("midrst_start", 32'(alu_start), 32'd0);
    check("midrst_pred_valid", 32'(pred_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tout_clr", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    base = n_start;
    for (int i = 0; i < 20; i++) tick();
    check("midrst_no_issue", 32'(n_start - base), 32'd0);
    check("midrst_idle", 32'({busy, pred_valid, cmd_ready}), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
